// File: rtl/user_seq_checker.sv
// user_seq_checker: checks player key presses against the round sequence read back from the pattern ROM.
// Optional per-press timeout is compiled in by defining USER_TIMEOUT_EN (adds parameter TIMEOUT_CYC).
module user_seq_checker #(
    parameter int p_key  = 4,
    parameter int p_addr = 4
`ifdef USER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 50000000
`endif
) (
    input  logic              clk,
    input  logic              R,
    input  logic              E,
    input  logic [p_key-1:0]  KEY,
    input  logic [p_addr-1:0] round,
    input  logic [p_key-1:0]  rom_data,
    output logic [p_addr-1:0] SEQUSER,
    output logic              pressed,
    output logic [p_key-1:0]  key_out,
    output logic              match,
    output logic              err,
    output logic              timeout
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_KEY = 3'd1,
        S_WAIT_REL = 3'd2,
        S_OK       = 3'd3,
        S_ERR      = 3'd4
    } state_t;

    localparam logic [p_key-1:0]  LP_KEY_ZERO  = {p_key{1'b0}};
    localparam logic [p_key-1:0]  LP_KEY_ONE   = {{(p_key-1){1'b0}}, 1'b1};
    localparam logic [p_addr-1:0] LP_ADDR_ZERO = {p_addr{1'b0}};
    localparam logic [p_addr-1:0] LP_ADDR_ONE  = {{(p_addr-1){1'b0}}, 1'b1};

    function automatic logic f_multi_hot(input logic [p_key-1:0] v);
        return (v & (v - LP_KEY_ONE)) != LP_KEY_ZERO;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [p_addr-1:0]   r_seq;
    logic [p_addr-1:0]   w_seq_nxt;
    logic [p_key-1:0]    r_key_out;
    logic [p_key-1:0]    w_key_out_nxt;
    logic [p_key-1:0]    r_key_q;
    logic                r_pressed;
    logic                w_pressed_nxt;
    logic                r_match;
    logic                w_match_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic                r_timeout;
    logic                w_timeout_nxt;
    logic                w_press;
    logic                w_tmo;

    // A press only counts once every key has been released in between.
    assign w_press = (KEY != LP_KEY_ZERO) && (r_key_q == LP_KEY_ZERO);

`ifdef USER_TIMEOUT_EN
    localparam int LP_TW = ($clog2(TIMEOUT_CYC) < 1) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [LP_TW-1:0] LP_TMAX = LP_TW'(TIMEOUT_CYC - 1);

    logic [LP_TW-1:0] r_tmo_cnt;

    // Idle-cycle counter, live only while waiting for a press.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_tmo_cnt <= {LP_TW{1'b0}};
        end else if ((r_state != S_WAIT_KEY) || w_press) begin
            r_tmo_cnt <= {LP_TW{1'b0}};
        end else if (r_tmo_cnt != LP_TMAX) begin
            r_tmo_cnt <= r_tmo_cnt + LP_TW'(1);
        end else begin
            r_tmo_cnt <= r_tmo_cnt;
        end
    end

    assign w_tmo = (r_state == S_WAIT_KEY) && (r_tmo_cnt == LP_TMAX);
`else
    assign w_tmo = 1'b0;
`endif

    // State, address and output registers.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_state   <= S_IDLE;
            r_seq     <= LP_ADDR_ZERO;
            r_key_out <= LP_KEY_ZERO;
            r_key_q   <= LP_KEY_ZERO;
            r_pressed <= 1'b0;
            r_match   <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_seq     <= w_seq_nxt;
            r_key_out <= w_key_out_nxt;
            r_key_q   <= KEY;
            r_pressed <= w_pressed_nxt;
            r_match   <= w_match_nxt;
            r_err     <= w_err_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_seq_nxt     = r_seq;
        w_key_out_nxt = r_key_out;
        w_pressed_nxt = 1'b0;
        w_match_nxt   = r_match;
        w_err_nxt     = r_err;
        w_timeout_nxt = r_timeout;
        case (r_state)
            S_IDLE: begin
                if (E) begin
                    w_state_nxt   = S_WAIT_KEY;
                    w_seq_nxt     = LP_ADDR_ZERO;
                    w_match_nxt   = 1'b0;
                    w_err_nxt     = 1'b0;
                    w_timeout_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_KEY: begin
                if (!E) begin
                    w_state_nxt = S_IDLE;
                    w_seq_nxt   = LP_ADDR_ZERO;
                end else if (w_press) begin
                    w_key_out_nxt = KEY;
                    w_pressed_nxt = 1'b1;
                    if (f_multi_hot(KEY) || (KEY != rom_data)) begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = 1'b1;
                    end else if (r_seq == round) begin
                        w_state_nxt = S_OK;
                        w_match_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT_REL;
                    end
                end else if (w_tmo) begin
                    w_state_nxt   = S_ERR;
                    w_err_nxt     = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT_KEY;
                end
            end
            S_WAIT_REL: begin
                if (!E) begin
                    w_state_nxt = S_IDLE;
                    w_seq_nxt   = LP_ADDR_ZERO;
                end else if (KEY == LP_KEY_ZERO) begin
                    w_state_nxt = S_WAIT_KEY;
                    w_seq_nxt   = r_seq + LP_ADDR_ONE;
                end else begin
                    w_state_nxt = S_WAIT_REL;
                end
            end
            S_OK: begin
                if (!E) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_OK;
                end
            end
            S_ERR: begin
                if (!E) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_ERR;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign SEQUSER = r_seq;
    assign pressed = r_pressed;
    assign key_out = r_key_out;
    assign match   = r_match;
    assign err     = r_err;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_user_seq_checker.sv
// Self-checking bench for user_seq_checker: vector table plus hand-written corner sequences, scoreboard compare.
module tb_user_seq_checker;

    logic       clk = 1'b0;
    logic       R   = 1'b0;
    logic       E   = 1'b0;
    logic [3:0] KEY = 4'd0;
    logic [3:0] round = 4'd0;
    logic [3:0] rom_data;
    logic [3:0] SEQUSER;
    logic       pressed;
    logic [3:0] key_out;
    logic       match;
    logic       err;
    logic       timeout;

    logic [3:0] rom [16];
    assign rom_data = rom[SEQUSER];

    always #5 clk = ~clk;

`ifdef USER_TIMEOUT_EN
    user_seq_checker #(.p_key(4), .p_addr(4), .TIMEOUT_CYC(16)) dut (
`else
    user_seq_checker #(.p_key(4), .p_addr(4)) dut (
`endif
        .clk(clk), .R(R), .E(E), .KEY(KEY), .round(round), .rom_data(rom_data),
        .SEQUSER(SEQUSER), .pressed(pressed), .key_out(key_out),
        .match(match), .err(err), .timeout(timeout)
    );

    typedef struct {
        logic       pressed;
        logic [3:0] key_out;
        logic [3:0] seq;
        logic       match;
        logic       err;
        logic       timeout;
    } exp_t;

    typedef struct {
        string      name;
        logic       e;
        logic [3:0] key;
        logic [3:0] rnd;
        exp_t       x;
    } vec_t;

    exp_t exp_q[$];
    vec_t vt[$];
    int   n_err = 0;
    int   n_chk = 0;

    function automatic exp_t mk(input logic p, input logic [3:0] ko, input logic [3:0] s,
                                input logic m, input logic e, input logic t);
        exp_t x;
        x.pressed = p; x.key_out = ko; x.seq = s; x.match = m; x.err = e; x.timeout = t;
        return x;
    endfunction

    task automatic add(input string name, input logic e, input logic [3:0] key, input logic [3:0] rnd,
                       input logic p, input logic [3:0] ko, input logic [3:0] s, input logic m, input logic er);
        vec_t v;
        v.name = name; v.e = e; v.key = key; v.rnd = rnd; v.x = mk(p, ko, s, m, er, 1'b0);
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t x;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            x = exp_q.pop_front();
            chk({tag, ".pressed"}, {3'd0, pressed}, {3'd0, x.pressed});
            chk({tag, ".key_out"}, key_out, x.key_out);
            chk({tag, ".SEQUSER"}, SEQUSER, x.seq);
            chk({tag, ".match"},   {3'd0, match},   {3'd0, x.match});
            chk({tag, ".err"},     {3'd0, err},     {3'd0, x.err});
            chk({tag, ".timeout"}, {3'd0, timeout}, {3'd0, x.timeout});
        end
    endtask

    task automatic drive(input logic e, input logic [3:0] k, input exp_t x, input string tag);
        E = e;
        KEY = k;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'd0;
        rom[0] = 4'b0001;
        rom[1] = 4'b0100;
        rom[2] = 4'b0010;
        rom[3] = 4'b1000;

        // name, E, KEY, round, exp pressed, key_out, SEQUSER, match, err
        add("c_start", 1'b1, 4'h0, 4'd2, 1'b0, 4'h0, 4'd0, 1'b0, 1'b0);
        add("c_p1",    1'b1, 4'h1, 4'd2, 1'b1, 4'h1, 4'd0, 1'b0, 1'b0);
        add("c_hold1", 1'b1, 4'h1, 4'd2, 1'b0, 4'h1, 4'd0, 1'b0, 1'b0);
        add("c_rel1",  1'b1, 4'h0, 4'd2, 1'b0, 4'h1, 4'd1, 1'b0, 1'b0);
        add("c_p2",    1'b1, 4'h4, 4'd2, 1'b1, 4'h4, 4'd1, 1'b0, 1'b0);
        add("c_rel2",  1'b1, 4'h0, 4'd2, 1'b0, 4'h4, 4'd2, 1'b0, 1'b0);
        add("c_p3",    1'b1, 4'h2, 4'd2, 1'b1, 4'h2, 4'd2, 1'b1, 1'b0);
        add("c_ok",    1'b1, 4'h0, 4'd2, 1'b0, 4'h2, 4'd2, 1'b1, 1'b0);
        add("c_edrop", 1'b0, 4'h0, 4'd2, 1'b0, 4'h2, 4'd2, 1'b1, 1'b0);
        add("c_idle",  1'b0, 4'h0, 4'd2, 1'b0, 4'h2, 4'd2, 1'b1, 1'b0);
        add("w_start", 1'b1, 4'h0, 4'd3, 1'b0, 4'h2, 4'd0, 1'b0, 1'b0);
        add("w_p1",    1'b1, 4'h1, 4'd3, 1'b1, 4'h1, 4'd0, 1'b0, 1'b0);
        add("w_rel1",  1'b1, 4'h0, 4'd3, 1'b0, 4'h1, 4'd1, 1'b0, 1'b0);
        add("w_bad",   1'b1, 4'h8, 4'd3, 1'b1, 4'h8, 4'd1, 1'b0, 1'b1);
        add("w_err",   1'b1, 4'h0, 4'd3, 1'b0, 4'h8, 4'd1, 1'b0, 1'b1);
        add("w_idle",  1'b0, 4'h0, 4'd3, 1'b0, 4'h8, 4'd1, 1'b0, 1'b1);
        add("m_start", 1'b1, 4'h0, 4'd3, 1'b0, 4'h8, 4'd0, 1'b0, 1'b0);
        add("m_two",   1'b1, 4'h3, 4'd3, 1'b1, 4'h3, 4'd0, 1'b0, 1'b1);
        add("m_idle",  1'b0, 4'h0, 4'd3, 1'b0, 4'h3, 4'd0, 1'b0, 1'b1);
        add("a_start", 1'b1, 4'h0, 4'd3, 1'b0, 4'h3, 4'd0, 1'b0, 1'b0);
        add("a_p1",    1'b1, 4'h1, 4'd3, 1'b1, 4'h1, 4'd0, 1'b0, 1'b0);
        add("a_rel1",  1'b1, 4'h0, 4'd3, 1'b0, 4'h1, 4'd1, 1'b0, 1'b0);
        add("a_p2",    1'b1, 4'h4, 4'd3, 1'b1, 4'h4, 4'd1, 1'b0, 1'b0);
        add("a_extra", 1'b1, 4'h6, 4'd3, 1'b0, 4'h4, 4'd1, 1'b0, 1'b0);
        add("a_abort", 1'b0, 4'h6, 4'd3, 1'b0, 4'h4, 4'd0, 1'b0, 1'b0);
        add("a_idle",  1'b0, 4'h0, 4'd3, 1'b0, 4'h4, 4'd0, 1'b0, 1'b0);

        // Reset state while R is held low.
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_q.push_back(mk(1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0));
        compare_out("reset");
        R = 1'b1;

        foreach (vt[i]) begin
            round = vt[i].rnd;
            drive(vt[i].e, vt[i].key, vt[i].x, vt[i].name);
        end

        // Key already held when E rises: no press until released and pressed again.
        round = 4'd3;
        drive(1'b0, 4'h1, mk(1'b0, 4'h4, 4'd0, 1'b0, 1'b0, 1'b0), "h_pre");
        drive(1'b1, 4'h1, mk(1'b0, 4'h4, 4'd0, 1'b0, 1'b0, 1'b0), "h_rise");
`ifdef USER_TIMEOUT_EN
        for (int i = 0; i < 10; i++)
`else
        for (int i = 0; i < 20; i++)
`endif
            drive(1'b1, 4'h1, mk(1'b0, 4'h4, 4'd0, 1'b0, 1'b0, 1'b0), "h_held");
        drive(1'b1, 4'h0, mk(1'b0, 4'h4, 4'd0, 1'b0, 1'b0, 1'b0), "h_rel");
        drive(1'b1, 4'h1, mk(1'b1, 4'h1, 4'd0, 1'b0, 1'b0, 1'b0), "h_repress");
        drive(1'b1, 4'h1, mk(1'b0, 4'h1, 4'd0, 1'b0, 1'b0, 1'b0), "h_after");
        drive(1'b1, 4'h0, mk(1'b0, 4'h1, 4'd1, 1'b0, 1'b0, 1'b0), "h_rel2");
        drive(1'b1, 4'h4, mk(1'b1, 4'h4, 4'd1, 1'b0, 1'b0, 1'b0), "h_p2");

        // Asynchronous reset between edges, while pressed is high.
        #3;
        R = 1'b0;
        #1;
        exp_q.push_back(mk(1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0));
        compare_out("async_rst");
        E = 1'b0;
        KEY = 4'h0;
        @(posedge clk);
        #5;
        R = 1'b1;
        drive(1'b0, 4'h0, mk(1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0), "post_rst");

`ifdef USER_TIMEOUT_EN
        drive(1'b1, 4'h0, mk(1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0), "t_start");
        for (int i = 0; i < 15; i++)
            drive(1'b1, 4'h0, mk(1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0), "t_wait");
        drive(1'b1, 4'h0, mk(1'b0, 4'h0, 4'd0, 1'b0, 1'b1, 1'b1), "t_expire");
        drive(1'b0, 4'h0, mk(1'b0, 4'h0, 4'd0, 1'b0, 1'b1, 1'b1), "t_idle");
        drive(1'b1, 4'h0, mk(1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0), "t2_start");
        for (int i = 0; i < 9; i++)
            drive(1'b1, 4'h0, mk(1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0), "t2_wait");
        drive(1'b1, 4'h1, mk(1'b1, 4'h1, 4'd0, 1'b0, 1'b0, 1'b0), "t2_press");
        for (int i = 0; i < 20; i++)
            drive(1'b1, 4'h1, mk(1'b0, 4'h1, 4'd0, 1'b0, 1'b0, 1'b0), "t2_held");
        drive(1'b1, 4'h0, mk(1'b0, 4'h1, 4'd1, 1'b0, 1'b0, 1'b0), "t2_rel");
        for (int i = 0; i < 15; i++)
            drive(1'b1, 4'h0, mk(1'b0, 4'h1, 4'd1, 1'b0, 1'b0, 1'b0), "t2_wait2");
        drive(1'b0, 4'h0, mk(1'b0, 4'h1, 4'd0, 1'b0, 1'b0, 1'b0), "t2_abort");
`else
        drive(1'b1, 4'h0, mk(1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0), "n_start");
        for (int i = 0; i < 40; i++)
            drive(1'b1, 4'h0, mk(1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0), "n_wait");
        drive(1'b0, 4'h0, mk(1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0), "n_abort");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
